ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one write port (ADDW1/DATA/WREN) and one read port (ADDR4/DATA4) of the CPU's multi-port RAM among N requesters, such as CPU store, loader/DMA and debug access. The arbiter accepts one access per cycle using a REQ/GNT handshake and drives registered address, data and write-enable to the RAM. It returns read data with fixed latency and range-checks addresses against the RAM depth. It sits between the requesting units and the RAM; ADDR1..ADDR3 stay directly owned by the CPU fetch/operand logic.

## Interface

Parameters:
- N, 3, number of requesters (2..8)
- MAX_ADDR, 1000, highest valid RAM word address

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- REQ  in  N  per-requester access request; held with operands until granted
- WE  in  N  per-requester op: 1 = write, 0 = read
- ADDR  in  N*12  per-requester word address; requester i uses bits [12i+11:12i]
- WDATA  in  N*16  per-requester write data; requester i uses bits [16i+15:16i]
- LOCK  in  N  per-requester bus lock; active only with RAM_ARB_LOCK_EN
- GNT  out  N  combinational one-hot grant; a transfer occurs at the posedge where REQ[i] and GNT[i] are both 1
- RVALID  out  N  one-cycle pulse; RDATA is valid for requester i
- RDATA  out  16  read data, shared by all requesters
- ERR  out  N  one-cycle pulse; the accepted address exceeded MAX_ADDR
- ADDW1  out  12  RAM write address, registered
- DATA  out  16  RAM write data, registered
- WREN  out  1  RAM write enable, registered
- ADDR4  out  12  RAM read address, registered
- DATA4  in  16  RAM read data, registered inside the RAM

## Operation

- Round-robin pointer LAST holds the index of the last granted requester. Search order is LAST+1, LAST+2, … mod N. The first requester with REQ high gets GNT. At most one GNT bit is high.
- At a transfer edge with requester i:
  - LAST becomes i.
  - ADDW1/ADDR4 load ADDR[i]. DATA loads WDATA[i].
  - WREN loads WE[i] & (ADDR[i] <= MAX_ADDR).
  - A read marker (valid, index i, out-of-range flag) is loaded into pipeline stage 1.
- With no transfer at an edge, WREN loads 0. ADDW1, ADDR4 and DATA hold their values.
- Stage 1 advances to stage 2 each edge. Stage 2 drives the outputs:
  - RVALID[i] pulses for reads only.
  - RDATA = DATA4 for an in-range read, 16'h0000 for an out-of-range read.
  - ERR[i] pulses for any out-of-range access, read or write, in the same cycle the RVALID slot would occur.
- Out-of-range writes never assert WREN.
- Ordering is strict issue order. A read issued the cycle after a write to the same address returns the new data, because the RAM write lands at edge E1 and the RAM read happens at edge E2.
- While rst is high, GNT = 0.

## Timing

- Reset values: GNT 0, RVALID 0, ERR 0, RDATA 0, WREN 0, ADDW1 0, ADDR4 0, DATA 0. LAST = N-1, so requester 0 has first priority. Stage 1 and stage 2 are invalid. The lock is released.
- Throughput: one access per cycle, back-to-back, across any mix of requesters.
- Write: transfer at edge E0; WREN high in cycle E0..E1; the RAM stores at E1.
- Read: transfer at edge E0; RAM samples ADDR4 at E1; RVALID and RDATA are high in cycle E1..E2.
- A requester may change REQ, WE, ADDR and WDATA only after its transfer edge.
- Reset asserted mid-operation:
  - WREN drops at the next edge, and a write registered at the previous edge is not completed if rst was already high at that edge.
  - In-flight reads are discarded; no RVALID is generated for them.
- Simultaneous requests from all N: each requester is granted once every N cycles. No requester waits more than N-1 cycles.

## Configuration

- RAM_ARB_LOCK_EN defined:
  - A transfer with LOCK[i]=1 sets lock owner = i.
  - While locked, only the owner can be granted, even when the owner's REQ is low and others are requesting.
  - A transfer by the owner with LOCK[i]=0 releases the lock at that edge.
  - rst releases the lock.
- RAM_ARB_LOCK_EN undefined: the LOCK input is ignored, no lock state is synthesized, and arbitration is pure round-robin.

## Test plan

- Reset then single requests:
  - Requester 0 writes 16'hBEEF to address 12'h010 -> WREN=1 with ADDW1=12'h010 one cycle after the transfer.
  - Requester 0 then reads 12'h010 -> RVALID[0] two cycles after its transfer, with RDATA=16'hBEEF.
- All three requesters hold reads of addresses 1, 2 and 3 from reset -> grants follow the order 0, 1, 2, 0 in successive cycles; RVALID follows the same order, two cycles behind each grant.
- Write 16'h1234 to address 5 followed immediately by a read of address 5 -> the read returns 16'h1234.
- Out-of-range accesses to address 12'h3E9 (1001):
  - Write -> WREN stays 0 and ERR pulses.
  - Read -> RVALID pulses with RDATA=0 and ERR pulses.
- rst pulsed one cycle after a read transfer -> no RVALID; all outputs return to 0; requester 0 is granted first afterwards.
- With RAM_ARB_LOCK_EN: requester 1 does a locked read of address 7, then a write of address 7 with LOCK low, while requesters 0 and 2 request continuously -> requesters 0 and 2 get no GNT until the unlocking transfer, then the grant passes to requester 2.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter sharing one RAM write port (ADDW1/DATA/
//               WREN) and one RAM read port (ADDR4/DATA4) among N requesters.
//               One access per cycle via REQ/GNT, registered RAM controls,
//               fixed-latency read return and address range checking.
//               Optional bus lock enabled by defining RAM_ARB_LOCK_EN.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               REQ/WE/ADDR/WDATA   - per-requester request and operands
//               LOCK                - per-requester lock (RAM_ARB_LOCK_EN)
//               GNT                 - combinational one-hot grant
//               RVALID/RDATA/ERR    - read return and range-error pulses
//               ADDW1/DATA/WREN     - registered RAM write port
//               ADDR4/DATA4         - registered RAM read address / read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
  parameter int N        = 3,
  parameter int MAX_ADDR = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    REQ,
  input  logic [N-1:0]    WE,
  input  logic [N*12-1:0] ADDR,
  input  logic [N*16-1:0] WDATA,
  input  logic [N-1:0]    LOCK,
  output logic [N-1:0]    GNT,
  output logic [N-1:0]    RVALID,
  output logic [15:0]     RDATA,
  output logic [N-1:0]    ERR,
  output logic [11:0]     ADDW1,
  output logic [15:0]     DATA,
  output logic            WREN,
  output logic [11:0]     ADDR4,
  input  logic [15:0]     DATA4
);

  localparam int              c_IW       = $clog2(N);
  localparam logic [12:0]     c_MAX_ADDR = 13'(MAX_ADDR);
  localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(N - 1);

  // Round-robin pointer and RAM-facing registers
  logic [c_IW-1:0] r_last_q,  w_last_d;
  logic [11:0]     r_addw1_q, w_addw1_d;
  logic [11:0]     r_addr4_q, w_addr4_d;
  logic [15:0]     r_data_q,  w_data_d;
  logic            r_wren_q,  w_wren_d;

  // Two-stage return pipeline: valid, is-read, out-of-range, requester index
  logic            r_s1_vld_q, w_s1_vld_d;
  logic            r_s1_rd_q,  w_s1_rd_d;
  logic            r_s1_oor_q, w_s1_oor_d;
  logic [c_IW-1:0] r_s1_idx_q, w_s1_idx_d;
  logic            r_s2_vld_q, w_s2_vld_d;
  logic            r_s2_rd_q,  w_s2_rd_d;
  logic            r_s2_oor_q, w_s2_oor_d;
  logic [c_IW-1:0] r_s2_idx_q, w_s2_idx_d;

  // Arbitration results
  logic [N-1:0]    w_gnt;
  logic [c_IW-1:0] w_sel;
  logic [c_IW-1:0] w_cand;
  logic            w_found;
  logic            w_xfer;
  logic [11:0]     w_addr_sel;
  logic [15:0]     w_wdata_sel;
  logic            w_we_sel;
  logic            w_lock_sel;
  logic            w_oor;

`ifdef RAM_ARB_LOCK_EN
  logic            r_lock_q,  w_lock_d;
  logic [c_IW-1:0] r_owner_q, w_owner_d;
`else
  // LOCK has no effect in this build
  logic            w_unused_lock;
  assign w_unused_lock = ^LOCK;
`endif

  // --------------------------------------------------------------------------
  // Grant: search LAST+1, LAST+2, ... mod N; first requester wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt   = '0;
    w_sel   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand = c_IW'((int'(r_last_q) + k) % N);
      if (!w_found && REQ[w_cand]) begin
        w_gnt[w_cand] = 1'b1;
        w_sel         = w_cand;
        w_found       = 1'b1;
      end
    end
`ifdef RAM_ARB_LOCK_EN
    // A held lock parks the grant on the owner even if the owner is idle
    if (r_lock_q) begin
      w_gnt            = '0;
      w_gnt[r_owner_q] = REQ[r_owner_q];
      w_sel            = r_owner_q;
    end
`endif
    if (rst) begin
      w_gnt = '0;
    end
  end

  assign GNT    = w_gnt;
  assign w_xfer = |w_gnt;

  // One-hot OR-mux of the granted requester's operands
  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    w_we_sel    = 1'b0;
    w_lock_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        w_addr_sel  = w_addr_sel  | ADDR[i*12 +: 12];
        w_wdata_sel = w_wdata_sel | WDATA[i*16 +: 16];
        w_we_sel    = w_we_sel    | WE[i];
        w_lock_sel  = w_lock_sel  | LOCK[i];
      end
    end
  end

  assign w_oor = ({1'b0, w_addr_sel} > c_MAX_ADDR);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_last_d   = r_last_q;
    w_addw1_d  = r_addw1_q;
    w_addr4_d  = r_addr4_q;
    w_data_d   = r_data_q;
    w_wren_d   = 1'b0;
    w_s1_vld_d = w_xfer;
    w_s1_rd_d  = ~w_we_sel;
    w_s1_oor_d = w_oor;
    w_s1_idx_d = w_sel;
    w_s2_vld_d = r_s1_vld_q;
    w_s2_rd_d  = r_s1_rd_q;
    w_s2_oor_d = r_s1_oor_q;
    w_s2_idx_d = r_s1_idx_q;
    if (w_xfer) begin
      w_last_d  = w_sel;
      w_addw1_d = w_addr_sel;
      w_addr4_d = w_addr_sel;
      w_data_d  = w_wdata_sel;
      // Out-of-range writes are dropped here so they never reach the RAM
      w_wren_d  = w_we_sel & ~w_oor;
    end
  end

`ifdef RAM_ARB_LOCK_EN
  // Every transfer rewrites the lock; while locked only the owner transfers,
  // so a LOCK=0 transfer by the owner is exactly the release.
  always_comb begin
    w_lock_d  = r_lock_q;
    w_owner_d = r_owner_q;
    if (w_xfer) begin
      w_lock_d  = w_lock_sel;
      w_owner_d = w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_q  <= 1'b0;
      r_owner_q <= '0;
    end else begin
      r_lock_q  <= w_lock_d;
      r_owner_q <= w_owner_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_q   <= c_LAST_RST;
      r_addw1_q  <= '0;
      r_addr4_q  <= '0;
      r_data_q   <= '0;
      r_wren_q   <= 1'b0;
      r_s1_vld_q <= 1'b0;
      r_s1_rd_q  <= 1'b0;
      r_s1_oor_q <= 1'b0;
      r_s1_idx_q <= '0;
      r_s2_vld_q <= 1'b0;
      r_s2_rd_q  <= 1'b0;
      r_s2_oor_q <= 1'b0;
      r_s2_idx_q <= '0;
    end else begin
      r_last_q   <= w_last_d;
      r_addw1_q  <= w_addw1_d;
      r_addr4_q  <= w_addr4_d;
      r_data_q   <= w_data_d;
      r_wren_q   <= w_wren_d;
      r_s1_vld_q <= w_s1_vld_d;
      r_s1_rd_q  <= w_s1_rd_d;
      r_s1_oor_q <= w_s1_oor_d;
      r_s1_idx_q <= w_s1_idx_d;
      r_s2_vld_q <= w_s2_vld_d;
      r_s2_rd_q  <= w_s2_rd_d;
      r_s2_oor_q <= w_s2_oor_d;
      r_s2_idx_q <= w_s2_idx_d;
    end
  end

  assign ADDW1 = r_addw1_q;
  assign ADDR4 = r_addr4_q;
  assign DATA  = r_data_q;
  assign WREN  = r_wren_q;

  // --------------------------------------------------------------------------
  // Return path: stage 2 lines up with DATA4 for the read issued two edges ago
  // --------------------------------------------------------------------------
  always_comb begin
    RVALID = '0;
    ERR    = '0;
    RDATA  = '0;
    if (r_s2_vld_q) begin
      if (r_s2_rd_q) begin
        RVALID[r_s2_idx_q] = 1'b1;
      end
      if (r_s2_oor_q) begin
        ERR[r_s2_idx_q] = 1'b1;
      end
      if (r_s2_rd_q && !r_s2_oor_q) begin
        RDATA = DATA4;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench for ram_port_arbiter (N=3) with
//               a behavioural RAM model on the ADDW1/DATA/WREN and
//               ADDR4/DATA4 ports. Lock scenario built with RAM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int c_N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     REQ;
  logic [2:0]     WE;
  logic [35:0]    ADDR;
  logic [47:0]    WDATA;
  logic [2:0]     LOCK;
  logic [2:0]     GNT;
  logic [2:0]     RVALID;
  logic [15:0]    RDATA;
  logic [2:0]     ERR;
  logic [11:0]    ADDW1;
  logic [15:0]    DATA;
  logic           WREN;
  logic [11:0]    ADDR4;
  logic [15:0]    DATA4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.N(c_N), .MAX_ADDR(1000)) dut (
    .clk    (clk),
    .rst    (rst),
    .REQ    (REQ),
    .WE     (WE),
    .ADDR   (ADDR),
    .WDATA  (WDATA),
    .LOCK   (LOCK),
    .GNT    (GNT),
    .RVALID (RVALID),
    .RDATA  (RDATA),
    .ERR    (ERR),
    .ADDW1  (ADDW1),
    .DATA   (DATA),
    .WREN   (WREN),
    .ADDR4  (ADDR4),
    .DATA4  (DATA4)
  );

  always #5 clk = ~clk;

  // RAM model: write at the edge WREN is seen, read data registered.
  // Unwritten words read back as 16'hA500 ^ address.
  logic [15:0]   mem [0:4095];
  logic [4095:0] wr_seen;
  logic          ram_clr;

  always @(posedge clk) begin
    if (ram_clr) begin
      wr_seen <= '0;
    end else if (WREN) begin
      mem[ADDW1]     <= DATA;
      wr_seen[ADDW1] <= 1'b1;
    end
    DATA4 <= wr_seen[ADDR4] ? mem[ADDR4] : (16'hA500 ^ {4'h0, ADDR4});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic we, input logic [11:0] a, input logic [15:0] d);
    WE[i]            = we;
    ADDR[i*12 +: 12] = a;
    WDATA[i*16 +: 16] = d;
  endtask

  initial begin
    rst     = 1'b1;
    ram_clr = 1'b1;
    REQ     = '0;
    WE      = '0;
    ADDR    = '0;
    WDATA   = '0;
    LOCK    = '0;

    // ---------------- reset ----------------
    tick();
    tick();
    REQ = 3'b111;
    #1;
    chk("gnt_in_reset", 32'(GNT), 32'h0);
    REQ = '0;
    tick();
    rst     = 1'b0;
    ram_clr = 1'b0;
    #1;
    chk("rst_wren",   32'(WREN),   32'h0);
    chk("rst_addw1",  32'(ADDW1),  32'h0);
    chk("rst_addr4",  32'(ADDR4),  32'h0);
    chk("rst_data",   32'(DATA),   32'h0);
    chk("rst_rvalid", 32'(RVALID), 32'h0);
    chk("rst_err",    32'(ERR),    32'h0);
    chk("rst_rdata",  32'(RDATA),  32'h0);

    // ---------------- single write then read by requester 0 ----------------
    REQ = 3'b001;
    set_op(0, 1'b1, 12'h010, 16'hBEEF);
    #1;
    chk("w0_gnt", 32'(GNT), 32'h1);
    tick();
    chk("w0_wren",  32'(WREN),  32'h1);
    chk("w0_addw1", 32'(ADDW1), 32'h010);
    chk("w0_data",  32'(DATA),  32'hBEEF);
    set_op(0, 1'b0, 12'h010, 16'h0000);
    #1;
    chk("r0_gnt", 32'(GNT), 32'h1);
    tick();
    REQ = '0;
    chk("r0_wren",  32'(WREN),  32'h0);
    chk("r0_addr4", 32'(ADDR4), 32'h010);
    tick();
    chk("r0_rvalid", 32'(RVALID), 32'h1);
    chk("r0_rdata",  32'(RDATA),  32'hBEEF);
    chk("r0_err",    32'(ERR),    32'h0);
    tick();
    chk("r0_rvalid_end", 32'(RVALID), 32'h0);

    // ---------------- round robin from reset ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    REQ = 3'b111;
    set_op(0, 1'b0, 12'd1, 16'h0);
    set_op(1, 1'b0, 12'd2, 16'h0);
    set_op(2, 1'b0, 12'd3, 16'h0);
    #1;
    chk("rr_gnt0", 32'(GNT), 32'h1);
    tick();
    chk("rr_gnt1",  32'(GNT),    32'h2);
    chk("rr_rv_t0", 32'(RVALID), 32'h0);
    tick();
    chk("rr_gnt2",  32'(GNT),    32'h4);
    chk("rr_rv0",   32'(RVALID), 32'h1);
    chk("rr_rd0",   32'(RDATA),  32'hA501);
    tick();
    chk("rr_gnt0b", 32'(GNT),    32'h1);
    chk("rr_rv1",   32'(RVALID), 32'h2);
    chk("rr_rd1",   32'(RDATA),  32'hA502);
    tick();
    REQ = '0;
    chk("rr_rv2",   32'(RVALID), 32'h4);
    chk("rr_rd2",   32'(RDATA),  32'hA503);
    tick();
    chk("rr_rv0b",  32'(RVALID), 32'h1);
    chk("rr_rd0b",  32'(RDATA),  32'hA501);
    tick();
    chk("rr_rv_idle", 32'(RVALID), 32'h0);

    // ---------------- write then immediate read of same address ----------------
    REQ = 3'b010;
    set_op(1, 1'b1, 12'd5, 16'h1234);
    #1;
    chk("raw_wgnt", 32'(GNT), 32'h2);
    tick();
    chk("raw_wren",  32'(WREN),  32'h1);
    chk("raw_addw1", 32'(ADDW1), 32'h005);
    REQ = 3'b100;
    set_op(2, 1'b0, 12'd5, 16'h0);
    #1;
    chk("raw_rgnt", 32'(GNT), 32'h4);
    tick();
    REQ = '0;
    tick();
    chk("raw_rvalid", 32'(RVALID), 32'h4);
    chk("raw_rdata",  32'(RDATA),  32'h1234);

    // ---------------- out-of-range write / read, in-range boundary ----------------
    REQ = 3'b001;
    set_op(0, 1'b1, 12'h3E9, 16'hDEAD);
    #1;
    chk("oor_wgnt", 32'(GNT), 32'h1);
    tick();
    chk("oor_w_wren",  32'(WREN),  32'h0);
    chk("oor_w_addw1", 32'(ADDW1), 32'h3E9);
    set_op(0, 1'b0, 12'h3E9, 16'h0);
    tick();
    chk("oor_w_err",    32'(ERR),    32'h1);
    chk("oor_w_rvalid", 32'(RVALID), 32'h0);
    set_op(0, 1'b1, 12'h3E8, 16'h7777);
    tick();
    REQ = '0;
    chk("oor_r_err",    32'(ERR),    32'h1);
    chk("oor_r_rvalid", 32'(RVALID), 32'h1);
    chk("oor_r_rdata",  32'(RDATA),  32'h0);
    chk("max_w_wren",   32'(WREN),   32'h1);
    chk("max_w_addw1",  32'(ADDW1),  32'h3E8);
    tick();
    chk("max_w_err",    32'(ERR),    32'h0);
    chk("idle_wren",    32'(WREN),   32'h0);

    // ---------------- reset one cycle after a read transfer ----------------
    REQ = 3'b001;
    set_op(0, 1'b0, 12'd1, 16'h0);
    #1;
    chk("rstmid_gnt", 32'(GNT), 32'h1);
    tick();
    REQ = '0;
    rst = 1'b1;
    tick();
    chk("rstmid_rvalid", 32'(RVALID), 32'h0);
    chk("rstmid_addr4",  32'(ADDR4),  32'h0);
    chk("rstmid_data",   32'(DATA),   32'h0);
    chk("rstmid_addw1",  32'(ADDW1),  32'h0);
    chk("rstmid_rdata",  32'(RDATA),  32'h0);
    rst = 1'b0;
    tick();
    chk("rstmid_rvalid2", 32'(RVALID), 32'h0);
    REQ = 3'b111;
    set_op(1, 1'b0, 12'd2, 16'h0);
    set_op(2, 1'b0, 12'd3, 16'h0);
    #1;
    chk("rstmid_first_gnt", 32'(GNT), 32'h1);
    tick();
    REQ = '0;
    tick();

`ifdef RAM_ARB_LOCK_EN
    // ---------------- locked access by requester 1 ----------------
    REQ  = 3'b010;
    LOCK = 3'b010;
    set_op(1, 1'b0, 12'd7, 16'h0);
    #1;
    chk("lk_gnt1", 32'(GNT), 32'h2);
    tick();
    REQ  = 3'b101;
    LOCK = 3'b000;
    #1;
    chk("lk_block_a", 32'(GNT), 32'h0);
    tick();
    chk("lk_block_b", 32'(GNT), 32'h0);
    REQ = 3'b111;
    set_op(1, 1'b1, 12'd7, 16'h5555);
    #1;
    chk("lk_unlock_gnt", 32'(GNT), 32'h2);
    tick();
    chk("lk_after_gnt", 32'(GNT), 32'h4);
    REQ = '0;
    tick();
`else
    // ---------------- LOCK ignored ----------------
    REQ  = 3'b010;
    LOCK = 3'b010;
    set_op(1, 1'b0, 12'd7, 16'h0);
    #1;
    chk("nolk_gnt1", 32'(GNT), 32'h2);
    tick();
    REQ  = 3'b101;
    #1;
    chk("nolk_gnt_next", 32'(GNT), 32'h4);
    REQ  = '0;
    LOCK = '0;
    tick();
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
